// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings and sampling helpers used by the receiver and transmitter.
package uart_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_CLEANUP   = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        START     = ST_START,
        DATA      = ST_DATA,
        STOP      = ST_STOP,
        CLEANUP   = ST_CLEANUP,
        WAIT_IDLE = ST_WAIT_IDLE
    } uart_state_t;

    localparam int CNT_W = 9;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_D,
    output logic o_Q
);

    logic meta;

    // NOTE: non-blocking assignments make each flop capture its pre-edge input; blocking ones would merge the chain into a single flop.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            meta <= 1'b1;
            o_Q  <= 1'b1;
        end else begin
            meta <= i_D;
            o_Q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote around the sample point.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Active
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_s;
    logic             sample;
    uart_state_t      r_state;
    logic [CNT_W-1:0] r_Clk_Count;
    logic [2:0]       r_Bit_Index;
    logic [7:0]       r_Shift;

    uart_rx_sync u_sync (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_D     (i_Rx_Serial),
        .o_Q     (rx_s)
    );

    // Both builds centre the sample on rx_s two cycles before the decision edge, so latency matches.
`ifdef UART_RX_MAJORITY_EN
    logic [2:0] rx_hist;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) rx_hist <= 3'b111;
        else          rx_hist <= {rx_hist[1:0], rx_s};
    end

    assign sample = maj3(rx_hist);
`else
    logic [1:0] rx_hist;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) rx_hist <= 2'b11;
        else          rx_hist <= {rx_hist[0], rx_s};
    end

    assign sample = rx_hist[1];
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state        <= IDLE;
            r_Clk_Count    <= '0;
            r_Bit_Index    <= '0;
            r_Shift        <= '0;
            o_Rx_DV        <= 1'b0;
            o_Rx_Byte      <= 8'h00;
            o_Rx_Frame_Err <= 1'b0;
            o_Rx_Active    <= 1'b0;
        end else begin
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    r_Clk_Count <= '0;
                    r_Bit_Index <= '0;
                    if (!rx_s) r_state <= START;
                end

                START: begin
                    if (r_Clk_Count == HALF_CNT) begin
                        r_Clk_Count <= '0;
                        if (!sample) begin
                            r_state     <= DATA;
                            o_Rx_Active <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_Clk_Count <= r_Clk_Count + 1'b1;
                    end
                end

                DATA: begin
                    if (r_Clk_Count == BIT_CNT) begin
                        r_Clk_Count          <= '0;
                        r_Shift[r_Bit_Index] <= sample;
                        r_Bit_Index          <= r_Bit_Index + 1'b1;
                        if (r_Bit_Index == 3'd7) r_state <= STOP;
                    end else begin
                        r_Clk_Count <= r_Clk_Count + 1'b1;
                    end
                end

                STOP: begin
                    if (r_Clk_Count == BIT_CNT) begin
                        r_Clk_Count <= '0;
                        if (sample) begin
                            o_Rx_Byte <= r_Shift;
                            o_Rx_DV   <= 1'b1;
                            r_state   <= CLEANUP;
                        end else begin
                            o_Rx_Frame_Err <= 1'b1;
                            r_state        <= WAIT_IDLE;
                        end
                    end else begin
                        r_Clk_Count <= r_Clk_Count + 1'b1;
                    end
                end

                CLEANUP: begin
                    o_Rx_Active <= 1'b0;
                    r_state     <= IDLE;
                end

                // A broken or stuck-low line yields one error, then waits for the line to recover.
                WAIT_IDLE: begin
                    if (rx_s) begin
                        o_Rx_Active <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-level line driver, byte scoreboard and pulse-rule monitor.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB  = 87;
    localparam int HALF = (CPB - 1) / 2;
    // Line edge to DV: two synchronizer cycles plus the receiver latency.
    localparam int EXP_LAT = 2 + HALF + 9 * CPB + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       dv;
    logic [7:0] rx_byte;
    logic       fe;
    logic       active;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    logic [7:0] glitch_byte = 8'h00;
    bit         skip_next = 1'b0;
    bit         dv_prev = 1'b0;
    bit         fe_prev = 1'b0;
    bit         active_seen = 1'b0;
    int         dv_count = 0;
    int         fe_count = 0;
    int         cyc = 0;
    int         last_dv_cyc = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (clk),
        .i_Rst_n        (rst_n),
        .i_Rx_Serial    (rx),
        .o_Rx_DV        (dv),
        .o_Rx_Byte      (rx_byte),
        .o_Rx_Frame_Err (fe),
        .o_Rx_Active    (active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Outputs change on posedge, so everything is observed on negedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dv) begin
                dv_count++;
                last_dv_cyc = cyc;
                check("dv_fe_exclusive", {31'd0, fe}, 0);
                check("dv_one_cycle", {31'd0, dv_prev}, 0);
                if (skip_next) begin
                    skip_next   = 1'b0;
                    glitch_byte = rx_byte;
                    last_good   = rx_byte;
                end else begin
                    check("dv_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 1);
                    if (exp_q.size() != 0) begin
                        last_good = exp_q.pop_front();
                        check("rx_byte", {24'd0, rx_byte}, {24'd0, last_good});
                    end
                end
            end
            if (fe) begin
                fe_count++;
                check("fe_one_cycle", {31'd0, fe_prev}, 0);
                check("fe_byte_kept", {24'd0, rx_byte}, {24'd0, last_good});
            end
            if (dv_prev) check("active_low_after_dv", {31'd0, active}, 0);
            if (active) active_seen = 1'b1;
        end
        dv_prev = dv;
        fe_prev = fe;
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop_bit, CPB);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv0, fe0, t0;
        logic [7:0] b;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_dv", {31'd0, dv}, 0);
        check("reset_fe", {31'd0, fe}, 0);
        check("reset_active", {31'd0, active}, 0);
        check("reset_byte", {24'd0, rx_byte}, 0);
        rst_n = 1'b1;
        hold(1'b1, 2 * CPB);

        // Single frame with latency measurement.
        dv0 = dv_count;
        fe0 = fe_count;
        t0  = cyc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        hold(1'b1, CPB);
        check("a5_dv_count", dv_count - dv0, 1);
        check("a5_no_fe", fe_count - fe0, 0);
        check("a5_latency_window",
              ((last_dv_cyc - t0 >= EXP_LAT - 1) && (last_dv_cyc - t0 <= EXP_LAT + 1)) ? 32'd1 : 32'd0, 1);

        // Back-to-back frames, no idle between stop and next start.
        dv0 = dv_count;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        hold(1'b1, CPB);
        check("b2b_dv_count", dv_count - dv0, 3);

        // Short low glitch on an idle line must be ignored.
        dv0 = dv_count;
        fe0 = fe_count;
        active_seen = 1'b0;
        hold(1'b0, 20);
        hold(1'b1, 3 * CPB);
        check("glitch_no_dv", dv_count - dv0, 0);
        check("glitch_no_fe", fe_count - fe0, 0);
        check("glitch_active_low", {31'd0, active_seen}, 0);
        check("glitch_state_idle", 32'(dut.r_state), 32'(IDLE));

        // Bad stop bit followed by a long break: exactly one error.
        dv0 = dv_count;
        fe0 = fe_count;
        send_frame(8'h3C, 1'b0);
        hold(1'b0, 2000);
        hold(1'b1, 2 * CPB);
        check("break_one_fe", fe_count - fe0, 1);
        check("break_no_dv", dv_count - dv0, 0);
        check("break_byte_kept", {24'd0, rx_byte}, 32'h55);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        hold(1'b1, CPB);
        check("after_break_dv", dv_count - dv0, 1);

        // Reset during data bit 4 of 8'hC3.
        dv0 = dv_count;
        b = 8'hC3;
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(b[i], CPB);
        hold(b[4], CPB / 2);
        rst_n = 1'b0;
        #1;
        check("midreset_dv", {31'd0, dv}, 0);
        check("midreset_fe", {31'd0, fe}, 0);
        check("midreset_active", {31'd0, active}, 0);
        check("midreset_byte", {24'd0, rx_byte}, 0);
        last_good = 8'h00;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 2 * CPB);
        check("midreset_no_dv", dv_count - dv0, 0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        hold(1'b1, CPB);
        check("after_reset_dv", dv_count - dv0, 1);

        // One-cycle inverted glitch at each data-bit midpoint of 8'h96.
        dv0 = dv_count;
        b = 8'h96;
`ifdef UART_RX_MAJORITY_EN
        exp_q.push_back(b);
`else
        skip_next = 1'b1;
`endif
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            hold(b[i], HALF - 1);
            hold(~b[i], 1);
            hold(b[i], CPB - HALF);
        end
        hold(1'b1, CPB);
        hold(1'b1, CPB);
        check("midglitch_dv", dv_count - dv0, 1);
`ifndef UART_RX_MAJORITY_EN
        $display("note: single-sample build received %0h for glitched 96", glitch_byte);
`endif

        // Random bytes with random idle gaps (zero gap means back-to-back).
        dv0 = dv_count;
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            hold(1'b1, $urandom_range(0, 2 * CPB));
        end
        hold(1'b1, 2 * CPB);
        check("random_dv_count", dv_count - dv0, 8);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning i_Clock cycles per serial bit; legal range 4..511.
REQ-002 SHALL have port i_Clock  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_Rx_Serial  input  1  asynchronous serial line; idle high.
REQ-005 SHALL have port o_Rx_DV  output  1  one-cycle pulse when o_Rx_Byte holds a new, valid byte.
REQ-006 SHALL have port o_Rx_Byte  output  8  last good received byte.
REQ-007 SHALL have port o_Rx_Frame_Err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-008 SHALL have port o_Rx_Active  output  1  high from a confirmed start bit until return to IDLE.

Function
REQ-009 SHALL pass i_Rx_Serial through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-010 SHALL receive 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, CLEANUP, WAIT_IDLE.
REQ-012 IDLE: clock counter and bit index held at 0; rx_s == 0 -> START.
REQ-013 START: count to (CLKS_PER_BIT-1)/2 (integer division); then rx_s == 0 -> DATA with counter cleared; rx_s == 1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: each bit is sampled after CLKS_PER_BIT cycles (mid-bit) into shift position r_Bit_Index; after index 7 -> STOP.
REQ-015 STOP: sample after CLKS_PER_BIT cycles; 1 -> load o_Rx_Byte and pulse o_Rx_DV, then -> CLEANUP; 0 -> pulse o_Rx_Frame_Err, leave o_Rx_Byte unchanged, then -> WAIT_IDLE.
REQ-016 CLEANUP: one cycle, o_Rx_Active deasserts, -> IDLE.
REQ-017 WAIT_IDLE: stay until rx_s == 1 (break / stuck-low line), then -> IDLE; at most one error pulse per low period.
REQ-018 o_Rx_DV and o_Rx_Frame_Err SHALL never assert in the same cycle and SHALL each be exactly one cycle wide.
REQ-019 o_Rx_DV SHALL rise within 1 cycle of the stop-bit sample point; total latency from the synchronized start falling edge = (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 2 cycles (+-1).
REQ-020 Back-to-back frames (a new start bit immediately after the stop-bit midpoint) SHALL be received without loss.
REQ-021 The clock counter SHALL be 9 bits wide and SHALL never wrap within a bit period.

Reset
REQ-022 Assertion of i_Rst_n low SHALL immediately force: state IDLE, counters 0, synchronizer flops 1, o_Rx_DV 0, o_Rx_Frame_Err 0, o_Rx_Active 0, o_Rx_Byte 8'h00.
REQ-023 Reset mid-frame SHALL discard the partial byte; reception restarts only on the next falling edge after release.

Configuration
REQ-024 With UART_RX_MAJORITY_EN defined, each sample (start confirm, data, stop) SHALL be the 2-of-3 majority of rx_s at sample point -1, 0, +1 cycles, using a 3-bit history register.
REQ-025 Without UART_RX_MAJORITY_EN, each sample SHALL be the single rx_s value at the sample point; latency is identical in both builds.

Structure
REQ-026 State encodings (3-bit localparams) SHALL live in shared package uart_pkg, also usable by the transmitter.
REQ-027 The 2-flop synchronizer SHALL be a sub-module, uart_rx_sync (reset value 1); everything else is in uart_rx.

Verification (CLKS_PER_BIT=87, line driven by a bit-accurate model)
REQ-028 Sending 8'hA5 -> one o_Rx_DV pulse with o_Rx_Byte == 8'hA5, o_Rx_Frame_Err never asserted, o_Rx_Active low 1 cycle after the pulse.
REQ-029 Sending 8'h00, 8'hFF, 8'h55 back-to-back with no idle gap -> three DV pulses in order with the correct bytes.
REQ-030 A 20-cycle low glitch on the idle line -> no DV, no error, o_Rx_Active stays 0, state back to IDLE.
REQ-031 Sending 8'h3C with the stop bit forced low, then holding the line low for 2000 cycles -> exactly one o_Rx_Frame_Err pulse, o_Rx_Byte keeps its previous value; after the line returns high, 8'h81 is received correctly.
REQ-032 i_Rst_n pulsed low during data bit 4 of 8'hC3 -> all outputs at reset values immediately, no DV for that frame, next frame 8'h12 received correctly.
REQ-033 (UART_RX_MAJORITY_EN) A one-cycle inverted glitch at each data-bit midpoint of 8'h96 -> o_Rx_Byte == 8'h96; without the macro the bench records the corrupted byte.
